// File: rtl/misc_op_sequencer.sv
// Misc-opcode sequencer: buffers 3-bit misc opcodes, translates them to 7-bit
// execution opcodes and issues them one at a time on a valid/ready port.
module misc_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [2:0]       in_misc,
  output logic             in_ready,
  output logic             issue_valid,
  output logic [6:0]       issue_opcode,
  input  logic             issue_ready,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DECODE  = 2'd1;
  localparam logic [1:0] ISSUE   = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [1:0]    state;
  logic [2:0]    op_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          handshake;

  function automatic logic [6:0] xlat(input logic [2:0] code);
    logic [6:0] op;
    case (code)
      3'b000:  op = 7'h61;
      3'b001:  op = 7'h60;
      3'b010:  op = 7'h09;
      3'b011:  op = 7'h08;
      3'b100:  op = 7'h66;
      3'b101:  op = 7'h67;
      3'b110:  op = 7'h62;
      default: op = 7'h00;
    endcase
    return op;
  endfunction

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign full      = (occ == FULL_CNT);
  assign empty     = (occ == '0);
  assign in_ready  = !full && !flush && !rst;
  assign push      = in_valid && in_ready;
  assign handshake = (state == ISSUE) && issue_ready;
  assign pop       = !empty && ((state == IDLE) || handshake);

  assign issue_valid = (state == ISSUE);
  assign illegal     = (state == ILLEGAL);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_misc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // A handshake landing in a flush cycle still counts; flush only parks the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= '0;
      issue_opcode <= '0;
      issue_count  <= '0;
    end else begin
      if (handshake) begin
        issue_count <= issue_count + 1'b1;
      end
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!empty) begin
              op_q  <= mem[rd_ptr];
              state <= DECODE;
            end
          end
          DECODE: begin
            if (op_q == 3'b111) begin
              state <= ILLEGAL;
            end else begin
              issue_opcode <= xlat(op_q);
              state        <= ISSUE;
            end
          end
          ISSUE: begin
            if (issue_ready) begin
              if (!empty) begin
                op_q  <= mem[rd_ptr];
                state <= DECODE;
              end else begin
                state <= IDLE;
              end
            end
          end
          ILLEGAL: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_misc_op_sequencer.sv
// Directed bench for misc_op_sequencer; a narrow-counter second instance
// shares the stimulus so counter wraparound is reachable in a short run.
module tb_misc_op_sequencer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_misc;
  logic        in_ready;
  logic        issue_valid;
  logic [6:0]  issue_opcode;
  logic        issue_ready;
  logic        illegal;
  logic [15:0] issue_count;

  logic        w_in_ready;
  logic        w_issue_valid;
  logic [6:0]  w_issue_opcode;
  logic        w_illegal;
  logic [2:0]  w_issue_count;

  int testsRun;
  int testsFailed;
  int cyc;
  int nIssue;
  int nIll;
  int pushIdx;
  int nPush;
  int stable;

  logic [2:0] pushCodes [0:7];
  logic [6:0] gotOp [0:15];
  int         gotCyc [0:15];
  int         illCyc [0:3];
  logic [6:0] expOps [0:6];

  misc_op_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_misc(in_misc),
    .in_ready(in_ready), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_ready(issue_ready), .illegal(illegal), .issue_count(issue_count)
  );

  misc_op_sequencer #(.DEPTH(4), .CNT_W(3)) dut_wrap (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_misc(in_misc),
    .in_ready(w_in_ready), .issue_valid(w_issue_valid), .issue_opcode(w_issue_opcode),
    .issue_ready(issue_ready), .illegal(w_illegal), .issue_count(w_issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clearRec();
    cyc     = 0;
    nIssue  = 0;
    nIll    = 0;
    pushIdx = 0;
    nPush   = 0;
  endtask

  // Samples the current cycle's handshake/illegal activity, then advances one edge.
  task automatic cycleRec();
    if (issue_valid && issue_ready && nIssue < 16) begin
      gotOp[nIssue]  = issue_opcode;
      gotCyc[nIssue] = cyc;
      nIssue++;
    end
    if (illegal && nIll < 4) begin
      illCyc[nIll] = cyc;
      nIll++;
    end
    tick();
  endtask

  task automatic applyStimulus(input int nCycles);
    logic accepted;
    for (int i = 0; i < nCycles; i++) begin
      if (pushIdx < nPush) begin
        in_valid = 1'b1;
        in_misc  = pushCodes[pushIdx];
      end else begin
        in_valid = 1'b0;
      end
      accepted = in_valid && in_ready;
      cycleRec();
      if (accepted) pushIdx++;
    end
  endtask

  task automatic doReset(input logic checkIt);
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_misc     = 3'b000;
    issue_ready = 1'b0;
    tick();
    tick();
    if (checkIt) begin
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_valid", 32'(issue_valid), 32'd0);
      checkOutput("rst_opcode", 32'(issue_opcode), 32'h00);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_count", 32'(issue_count), 32'd0);
    end
    rst = 1'b0;
    #1;
    if (checkIt) checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    clearRec();
  endtask

  task automatic loadSeven();
    for (int i = 0; i < 7; i++) pushCodes[i] = 3'(i);
    nPush = 7;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_misc     = 3'b000;
    issue_ready = 1'b0;
    clearRec();
    expOps[0] = 7'h61; expOps[1] = 7'h60; expOps[2] = 7'h09; expOps[3] = 7'h08;
    expOps[4] = 7'h66; expOps[5] = 7'h67; expOps[6] = 7'h62;

    // Single op latency: push, two cycles of IDLE/DECODE, then valid.
    doReset(1'b1);
    pushCodes[0] = 3'b000;
    nPush = 1;
    applyStimulus(1);
    checkOutput("lat_c1_valid", 32'(issue_valid), 32'd0);
    applyStimulus(1);
    checkOutput("lat_c2_valid", 32'(issue_valid), 32'd0);
    applyStimulus(1);
    checkOutput("lat_c3_valid", 32'(issue_valid), 32'd1);
    checkOutput("lat_c3_opcode", 32'(issue_opcode), 32'h61);
    issue_ready = 1'b1;
    applyStimulus(1);
    issue_ready = 1'b0;
    checkOutput("lat_count", 32'(issue_count), 32'd1);
    checkOutput("lat_idle_valid", 32'(issue_valid), 32'd0);
    checkOutput("lat_idle_illegal", 32'(illegal), 32'd0);

    // All seven legal codes streamed back-to-back.
    doReset(1'b0);
    loadSeven();
    issue_ready = 1'b1;
    applyStimulus(7);
    checkOutput("seq_full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(11);
    checkOutput("seq_n_issue", 32'(nIssue), 32'd7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("seq_op%0d", i), 32'(gotOp[i]), 32'(expOps[i]));
      checkOutput($sformatf("seq_cyc%0d", i), 32'(gotCyc[i]), 32'(3 + 2 * i));
    end
    checkOutput("seq_count", 32'(issue_count), 32'd7);
    checkOutput("seq_wrap_allones", 32'(w_issue_count), 32'd7);
    clearRec();
    pushCodes[0] = 3'b100;
    nPush = 1;
    applyStimulus(6);
    checkOutput("wrap_op", 32'(gotOp[0]), 32'h66);
    checkOutput("wrap_count16", 32'(issue_count), 32'd8);
    checkOutput("wrap_count3", 32'(w_issue_count), 32'd0);
    issue_ready = 1'b0;

    // Illegal entry in the middle is dropped with one pulse.
    doReset(1'b0);
    pushCodes[0] = 3'b011; pushCodes[1] = 3'b111; pushCodes[2] = 3'b101;
    nPush = 3;
    issue_ready = 1'b1;
    applyStimulus(12);
    checkOutput("ill_n_issue", 32'(nIssue), 32'd2);
    checkOutput("ill_op0", 32'(gotOp[0]), 32'h08);
    checkOutput("ill_cyc0", 32'(gotCyc[0]), 32'd3);
    checkOutput("ill_op1", 32'(gotOp[1]), 32'h67);
    checkOutput("ill_cyc1", 32'(gotCyc[1]), 32'd8);
    checkOutput("ill_n_pulse", 32'(nIll), 32'd1);
    checkOutput("ill_pulse_cyc", 32'(illCyc[0]), 32'd5);
    checkOutput("ill_count", 32'(issue_count), 32'd2);
    issue_ready = 1'b0;

    // Backpressure with a full FIFO behind a held 7'h66.
    doReset(1'b0);
    pushCodes[0] = 3'b100; pushCodes[1] = 3'b000; pushCodes[2] = 3'b001;
    pushCodes[3] = 3'b010; pushCodes[4] = 3'b011;
    nPush = 5;
    applyStimulus(5);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_valid", 32'(issue_valid), 32'd1);
    checkOutput("bp_opcode", 32'(issue_opcode), 32'h66);
    in_valid = 1'b1;
    in_misc  = 3'b110;
    #1;
    checkOutput("bp_reject_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (issue_valid && issue_opcode == 7'h66) stable++;
      tick();
    end
    checkOutput("bp_stable", 32'(stable), 32'd10);
    checkOutput("bp_count_held", 32'(issue_count), 32'd0);
    clearRec();
    issue_ready = 1'b1;
    applyStimulus(16);
    checkOutput("bp_n_issue", 32'(nIssue), 32'd5);
    checkOutput("bp_op0", 32'(gotOp[0]), 32'h66);
    checkOutput("bp_op1", 32'(gotOp[1]), 32'h61);
    checkOutput("bp_op2", 32'(gotOp[2]), 32'h60);
    checkOutput("bp_op3", 32'(gotOp[3]), 32'h09);
    checkOutput("bp_op4", 32'(gotOp[4]), 32'h08);
    checkOutput("bp_count", 32'(issue_count), 32'd5);
    issue_ready = 1'b0;

    // Flush mid-ISSUE with three entries queued.
    doReset(1'b0);
    pushCodes[0] = 3'b101; pushCodes[1] = 3'b000; pushCodes[2] = 3'b001; pushCodes[3] = 3'b010;
    nPush = 4;
    applyStimulus(4);
    checkOutput("fl_pre_valid", 32'(issue_valid), 32'd1);
    checkOutput("fl_pre_opcode", 32'(issue_opcode), 32'h67);
    flush = 1'b1;
    #1;
    checkOutput("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("fl_valid", 32'(issue_valid), 32'd0);
    checkOutput("fl_illegal", 32'(illegal), 32'd0);
    checkOutput("fl_post_in_ready", 32'(in_ready), 32'd1);
    checkOutput("fl_count", 32'(issue_count), 32'd0);
    checkOutput("fl_opcode_kept", 32'(issue_opcode), 32'h67);
    clearRec();
    issue_ready = 1'b1;
    applyStimulus(6);
    checkOutput("fl_empty_no_issue", 32'(nIssue), 32'd0);
    clearRec();
    pushCodes[0] = 3'b010;
    nPush = 1;
    applyStimulus(6);
    checkOutput("fl_after_n", 32'(nIssue), 32'd1);
    checkOutput("fl_after_op", 32'(gotOp[0]), 32'h09);
    checkOutput("fl_after_count", 32'(issue_count), 32'd1);
    issue_ready = 1'b0;

    // Handshake coinciding with flush still counts.
    doReset(1'b0);
    pushCodes[0] = 3'b011;
    nPush = 1;
    applyStimulus(3);
    checkOutput("flhs_valid", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_ready = 1'b0;
    checkOutput("flhs_count", 32'(issue_count), 32'd1);
    checkOutput("flhs_valid_after", 32'(issue_valid), 32'd0);

    // Reset with flush during ISSUE, narrow counter sitting at all-ones.
    doReset(1'b0);
    loadSeven();
    issue_ready = 1'b1;
    applyStimulus(18);
    checkOutput("rf_count16_pre", 32'(issue_count), 32'd7);
    checkOutput("rf_count3_allones", 32'(w_issue_count), 32'd7);
    clearRec();
    issue_ready = 1'b0;
    pushCodes[0] = 3'b100;
    nPush = 1;
    applyStimulus(3);
    checkOutput("rf_pre_valid", 32'(issue_valid), 32'd1);
    rst = 1'b1;
    flush = 1'b1;
    issue_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    checkOutput("rf_valid", 32'(issue_valid), 32'd0);
    checkOutput("rf_opcode", 32'(issue_opcode), 32'h00);
    checkOutput("rf_illegal", 32'(illegal), 32'd0);
    checkOutput("rf_count16", 32'(issue_count), 32'd0);
    checkOutput("rf_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rf_w_valid", 32'(w_issue_valid), 32'd0);
    checkOutput("rf_w_opcode", 32'(w_issue_opcode), 32'h00);
    checkOutput("rf_w_illegal", 32'(w_illegal), 32'd0);
    checkOutput("rf_w_count", 32'(w_issue_count), 32'd0);
    checkOutput("rf_w_in_ready", 32'(w_in_ready), 32'd0);
    rst = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b0;
    #1;
    checkOutput("rf_post_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/misc_op_sequencer.md
# misc_op_sequencer

Sequencer that sits between the misc-opcode stash and the execution-unit issue port. It buffers incoming 3-bit misc opcodes in a small FIFO, translates each to its 7-bit opcode, and presents them one at a time on a valid/ready issue interface. The illegal encoding 3'b111 is dropped and reported. The block also keeps a running issue count for performance monitoring.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of issue_count.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO and in-flight op.
- in_valid  in  1  stash offers an opcode.
- in_misc  in  3  misc opcode.
- in_ready  out  1  FIFO can accept.
- issue_valid  out  1  issue_opcode valid.
- issue_opcode  out  7  translated opcode.
- issue_ready  in  1  execution unit accepts.
- illegal  out  1  one-cycle pulse when a 3'b111 entry is dropped.
- issue_count  out  CNT_W  completed issues; wraps modulo 2^CNT_W.

## Operation
- FIFO
  - Write when in_valid && in_ready.
  - in_ready = !full && !flush && !rst. A push while full is not accepted, even if a pop happens in the same cycle.
  - Occupancy counter ranges 0..DEPTH. Pointers wrap modulo DEPTH.
- Translation: 000→7'h61, 001→7'h60, 010→7'h09, 011→7'h08, 100→7'h66, 101→7'h67, 110→7'h62. 111 is illegal.
- FSM states: IDLE, DECODE, ISSUE, ILLEGAL.
  - IDLE
    - FIFO non-empty: pop the head into op_q and go to DECODE.
    - Otherwise stay in IDLE.
  - DECODE
    - op_q == 3'b111: go to ILLEGAL.
    - Otherwise load issue_opcode from the table and go to ISSUE.
  - ISSUE
    - issue_valid = 1. issue_opcode is held stable until the handshake.
    - On issue_ready: increment issue_count.
      - FIFO non-empty: pop the next entry and go to DECODE.
      - FIFO empty: go to IDLE.
    - Without issue_ready: stay in ISSUE.
  - ILLEGAL
    - illegal = 1 for exactly this cycle. issue_count is unchanged.
    - Go to IDLE.
- issue_valid is high only in ISSUE. illegal is high only in ILLEGAL.
- flush (when not in reset)
  - Next cycle: FIFO empty, state IDLE, issue_valid = 0, illegal = 0.
  - Any handshake in the flush cycle still completes and counts.
  - issue_opcode and issue_count are preserved.
- rst: overrides flush and clears everything.
- A pop from the FIFO and an accepted push in the same cycle leave occupancy unchanged.

## Timing
- Reset values:
  - state IDLE, FIFO empty.
  - in_ready 0 during rst, 1 on the first cycle after.
  - issue_valid 0, issue_opcode 7'h00, illegal 0, issue_count 0.
- Latency: push accepted at edge N (FIFO empty, IDLE):
  - IDLE pops at edge N+1.
  - DECODE at N+1→N+2.
  - issue_valid high in the cycle after edge N+2, i.e. 3 cycles from push to valid.
- Throughput: one issue per 2 cycles with issue_ready held high (ISSUE→DECODE→ISSUE).
- Illegal entry: illegal pulses 2 cycles after the entry is popped. The next entry reaches ISSUE no earlier than 3 cycles after ILLEGAL.
- Backpressure: issue_valid and issue_opcode stay stable for any number of cycles with issue_ready low.
- issue_count updates on the edge that completes the handshake.

## Test plan
- Reset then push 000: in_ready=1 on the first post-reset cycle. issue_valid rises 3 cycles after the push with issue_opcode=7'h61. Handshake → issue_count=1, state IDLE.
- Push all seven legal codes 000..110 with issue_ready=1:
  - Issues in order 61,60,09,08,66,67,62, every 2 cycles.
  - in_ready drops after DEPTH outstanding entries.
  - issue_count=7.
- Push 011,111,101: issues 7'h08, then one illegal pulse with no issue for 111, then 7'h67. issue_count=2.
- Fill the FIFO to 4 with issue_ready=0 while ISSUE holds 7'h66:
  - in_ready=0, and a push attempt is not stored.
  - issue_opcode stays stable for 10 cycles.
  - Release: 5 issues total.
- Flush mid-ISSUE with 3 entries queued and issue_ready=0:
  - Next cycle issue_valid=0, FIFO empty, issue_count unchanged.
  - A subsequent push 010 issues 7'h09.
- Assert rst during ISSUE with flush also high: all outputs return to reset values next cycle. Set issue_count to 16'hFFFF first and confirm it reads 0 after reset; separately confirm one issue from 16'hFFFF wraps to 0.
